// File: rtl/fp16_divide_if.sv
// ---------------------------------------------------------------------------
// fp16_divide_if
//   Operand/result bundle for the iterative FP16 divider.
//   in_A, in_B   : dividend / divisor {sign, exp, frac}
//   in_En        : start request
//   out_Out      : quotient, held until the next result
//   out_Ready    : one-cycle pulse when out_Out is written
//   out_Busy     : operation in progress
//   master drives operands and start; slave (the divider) drives results.
// ---------------------------------------------------------------------------
interface fp16_divide_if #(
  parameter int W = 16
);
  logic [W-1:0] in_A;
  logic [W-1:0] in_B;
  logic         in_En;
  logic [W-1:0] out_Out;
  logic         out_Ready;
  logic         out_Busy;

  modport master (
    output in_A, in_B, in_En,
    input  out_Out, out_Ready, out_Busy
  );

  modport slave (
    input  in_A, in_B, in_En,
    output out_Out, out_Ready, out_Busy
  );
endinterface

// File: rtl/fp16_divide.sv
// ---------------------------------------------------------------------------
// fp16_divide
//   Iterative half-precision divider, out_Out = in_A / in_B.
//   Restoring mantissa division, one quotient bit per clock, truncating,
//   no denormals and no NaN output. Fixed latency of FRAC_W+3 edges.
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : fp16_divide_if.slave (in_A, in_B, in_En, out_Out, out_Ready, out_Busy)
// Timing
//   Accept at edge 0, DIVIDE on edges 1..FRAC_W+2, result written at edge
//   FRAC_W+3 together with out_Ready. out_Busy drops when the last quotient
//   bit is produced, so the NORM cycle is also an accept slot: an in_En seen
//   at the result edge starts the next operation (13-cycle issue rate).
// ---------------------------------------------------------------------------
module fp16_divide #(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10,
  parameter int BIAS   = 15
) (
  input  logic          clk,
  input  logic          rst,
  fp16_divide_if.slave  bus
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int QW = FRAC_W + 2;          // quotient / remainder width
  localparam int EW = EXP_W + 2;           // signed working exponent width
  localparam int CW = $clog2(QW);

  localparam logic [EXP_W-1:0]     EXP_ONES  = {EXP_W{1'b1}};
  localparam logic signed [EW-1:0] EXP_MAX_S = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ZERO_S    = '0;

  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM} state_t;
  typedef enum logic [1:0] {C_NORMAL, C_ZERO, C_INF} cls_t;

  state_t                r_state, w_state_next;
  cls_t                  r_cls,   w_cls_next;
  logic                  r_sign,  w_sign_next;
  logic signed [EW-1:0]  r_exp,   w_exp_next;
  logic [QW-1:0]         r_rem,   w_rem_next;
  logic [FRAC_W:0]       r_div,   w_div_next;
  logic [QW-1:0]         r_q,     w_q_next;
  logic [CW-1:0]         r_cnt,   w_cnt_next;
  logic [W-1:0]          r_out,   w_out_next;
  logic                  r_ready, w_ready_next;
  logic                  r_busy,  w_busy_next;

  logic [EXP_W-1:0]      w_a_exp, w_b_exp;
  logic                  w_accept;
  logic                  w_ge;
  logic [QW-1:0]         w_rem_sel;
  logic signed [EW-1:0]  w_exp_adj;
  logic [FRAC_W-1:0]     w_frac;
  logic [W-1:0]          w_result;

  assign w_a_exp  = bus.in_A[W-2 -: EXP_W];
  assign w_b_exp  = bus.in_B[W-2 -: EXP_W];
  assign w_accept = bus.in_En && ((r_state == S_IDLE) || (r_state == S_NORM));

  // One restoring step: subtract only when the remainder covers the divisor.
  assign w_ge      = (r_rem >= {1'b0, r_div});
  assign w_rem_sel = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

  // Quotient lies in [0.5, 2): a clear MSB means one normalising shift.
  assign w_exp_adj = r_q[QW-1] ? r_exp : (r_exp - EW'(1));
  assign w_frac    = r_q[QW-1] ? r_q[QW-2:1] : r_q[QW-3:0];

  always_comb begin
    w_result = {r_sign, w_exp_adj[EXP_W-1:0], w_frac};
    if (r_cls == C_INF || w_exp_adj >= EXP_MAX_S)
      w_result = {r_sign, EXP_ONES, {FRAC_W{1'b0}}};
    else if (r_cls == C_ZERO || w_exp_adj <= ZERO_S)
      w_result = {r_sign, {(W-1){1'b0}}};
  end

  always_comb begin
    w_state_next = r_state;
    w_cls_next   = r_cls;
    w_sign_next  = r_sign;
    w_exp_next   = r_exp;
    w_rem_next   = r_rem;
    w_div_next   = r_div;
    w_q_next     = r_q;
    w_cnt_next   = r_cnt;
    w_out_next   = r_out;
    w_ready_next = 1'b0;
    w_busy_next  = r_busy;

    case (r_state)
      S_DIVIDE: begin
        // Shifting the new bit in at the LSB lands bit k at q[cnt] after
        // the full QW iterations, since q starts cleared.
        w_q_next   = {r_q[QW-2:0], w_ge};
        w_rem_next = {w_rem_sel[QW-2:0], 1'b0};
        w_cnt_next = r_cnt - CW'(1);
        if (r_cnt == '0) begin
          w_state_next = S_NORM;
          w_busy_next  = 1'b0;
        end
      end
      S_NORM: begin
        w_out_next   = w_result;
        w_ready_next = 1'b1;
        w_state_next = S_IDLE;
      end
      default: ;
    endcase

    if (w_accept) begin
      w_sign_next  = bus.in_A[W-1] ^ bus.in_B[W-1];
      w_exp_next   = EW'({2'b00, w_a_exp}) - EW'({2'b00, w_b_exp}) + EW'(BIAS);
      w_rem_next   = {2'b01, bus.in_A[FRAC_W-1:0]};
      w_div_next   = {1'b1, bus.in_B[FRAC_W-1:0]};
      w_q_next     = '0;
      w_cnt_next   = CW'(QW - 1);
      if (w_b_exp == '0)          w_cls_next = C_INF;   // makes 0/0 infinite
      else if (w_a_exp == '0)     w_cls_next = C_ZERO;
      else if (w_a_exp == EXP_ONES) w_cls_next = C_INF;
      else if (w_b_exp == EXP_ONES) w_cls_next = C_ZERO;
      else                        w_cls_next = C_NORMAL;
      w_busy_next  = 1'b1;
      w_state_next = S_DIVIDE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cls   <= C_NORMAL;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cls   <= w_cls_next;
      r_sign  <= w_sign_next;
      r_exp   <= w_exp_next;
      r_rem   <= w_rem_next;
      r_div   <= w_div_next;
      r_q     <= w_q_next;
      r_cnt   <= w_cnt_next;
      r_out   <= w_out_next;
      r_ready <= w_ready_next;
      r_busy  <= w_busy_next;
    end
  end

  assign bus.out_Out   = r_out;
  assign bus.out_Ready = r_ready;
  assign bus.out_Busy  = r_busy;

endmodule

// File: tb/tb_fp16_divide.sv
// ---------------------------------------------------------------------------
// tb_fp16_divide
//   Self-checking bench for fp16_divide: directed vectors with known
//   quotients, handshake/back-to-back timing, reset mid-operation, and
//   random operands checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fp16_divide;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp16_divide_if #(.W(16)) bus ();

  fp16_divide dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Reference: real-number quotient of the mantissas, truncated to 12 bits.
  function automatic logic [15:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    logic s;
    int ea, eb, ma, mb, q, e, fr;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    ma = 1024 + int'(a[9:0]);
    mb = 1024 + int'(b[9:0]);
    if (eb == 0)  return {s, 5'h1F, 10'h0};
    if (ea == 0)  return {s, 15'h0};
    if (ea == 31) return {s, 5'h1F, 10'h0};
    if (eb == 31) return {s, 15'h0};
    q = (ma * 2048) / mb;
    e = ea - eb + 15;
    if (q >= 2048) fr = (q >> 1) % 1024;
    else begin
      fr = q % 1024;
      e  = e - 1;
    end
    if (e >= 31) return {s, 5'h1F, 10'h0};
    if (e <= 0)  return {s, 15'h0};
    return {s, 5'(e), 10'(fr)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepting edge is the first tick.
  task automatic start(input logic [15:0] a, input logic [15:0] b);
    bus.in_A  = a;
    bus.in_B  = b;
    bus.in_En = 1'b1;
    tick();
    bus.in_En = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] expv);
    start(a, b);
    check_eq("busy_after_accept", {15'h0, bus.out_Busy}, 16'h1);
    repeat (12) tick();
    check_eq("ready_early", {15'h0, bus.out_Ready}, 16'h0);
    tick();
    check_eq("ready_edge13", {15'h0, bus.out_Ready}, 16'h1);
    check_eq($sformatf("quot_%h_%h", a, b), bus.out_Out, expv);
    tick();
    check_eq("ready_pulse_end", {15'h0, bus.out_Ready}, 16'h0);
    $display("op %h / %h -> %h (expected %h)", a, b, bus.out_Out, expv);
  endtask

  logic [15:0] dir_a [8] = '{16'h4600, 16'h3C00, 16'hC000, 16'h8000,
                             16'h3C00, 16'h0000, 16'h7800, 16'h0400};
  logic [15:0] dir_b [8] = '{16'h4000, 16'h4200, 16'h3800, 16'h4000,
                             16'h0000, 16'h0000, 16'h0400, 16'h7800};
  logic [15:0] dir_q [8] = '{16'h4200, 16'h3555, 16'hC400, 16'h8000,
                             16'h7C00, 16'h7C00, 16'h7C00, 16'h0000};

  initial begin
    int ready_seen;
    logic [15:0] ra, rb;

    rst       = 1'b1;
    bus.in_A  = '0;
    bus.in_B  = '0;
    bus.in_En = 1'b0;
    tick();
    tick();
    check_eq("reset_out", bus.out_Out, 16'h0000);
    check_eq("reset_ready", {15'h0, bus.out_Ready}, 16'h0);
    check_eq("reset_busy", {15'h0, bus.out_Busy}, 16'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_op(dir_a[i], dir_b[i], dir_q[i]);

    // in_En while busy is ignored; re-issue lands on the result edge.
    start(16'h4600, 16'h4000);                 // edge 0
    repeat (4) tick();                          // edge 4
    bus.in_A  = 16'h3C00;
    bus.in_B  = 16'h4200;
    bus.in_En = 1'b1;
    tick();                                     // edge 5: ignored
    bus.in_En = 1'b0;
    repeat (7) tick();                          // edge 12
    check_eq("busy_norm_cycle", {15'h0, bus.out_Busy}, 16'h0);
    bus.in_A  = 16'hC000;
    bus.in_B  = 16'h3800;
    bus.in_En = 1'b1;
    tick();                                     // edge 13: result + re-accept
    bus.in_En = 1'b0;
    bus.in_A  = 16'h0000;
    bus.in_B  = 16'h0000;
    check_eq("b2b_first_ready", {15'h0, bus.out_Ready}, 16'h1);
    check_eq("b2b_first_out", bus.out_Out, 16'h4200);
    check_eq("b2b_busy_again", {15'h0, bus.out_Busy}, 16'h1);
    repeat (12) tick();                         // edge 25
    check_eq("b2b_ready_early", {15'h0, bus.out_Ready}, 16'h0);
    tick();                                     // edge 26
    check_eq("b2b_second_ready", {15'h0, bus.out_Ready}, 16'h1);
    check_eq("b2b_second_out", bus.out_Out, 16'hC400);
    $display("back-to-back: second result %h at edge 26", bus.out_Out);
    tick();

    // Reset during an operation abandons it.
    start(16'h4600, 16'h4000);                  // edge 0
    repeat (6) tick();                          // edge 6
    @(posedge clk);                             // edge 7
    #1 rst = 1'b1;
    #1;
    check_eq("midrst_out", bus.out_Out, 16'h0000);
    check_eq("midrst_ready", {15'h0, bus.out_Ready}, 16'h0);
    check_eq("midrst_busy", {15'h0, bus.out_Busy}, 16'h0);
    tick();
    tick();
    rst = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.out_Ready) ready_seen++;
    end
    check_eq("midrst_no_ready", 16'(ready_seen), 16'h0);
    $display("reset mid-op: %0d stray ready pulses", ready_seen);
    run_op(16'h3C00, 16'h4200, 16'h3555);

    // Random operands; some exponents forced to the reserved extremes.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: ra[14:10] = 5'h00;
        1: rb[14:10] = 5'h00;
        2: ra[14:10] = 5'h1F;
        3: rb[14:10] = 5'h1F;
        default: ;
      endcase
      run_op(ra, rb, ref_div(ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
